// File: rtl/branch_pkg.sv
// Branch-type encoding and saturating-counter helpers shared by the
// branch-condition unit, the decoder and the branch predictor.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BGE  = 3'b100,
        BR_BLTU = 3'b101,
        BR_BGEU = 3'b110,
        BR_JUMP = 3'b111
    } br_type_e;

    // Default counter width and its weakly-not-taken reset value
    localparam int             CTR_BITS_DEF = 2;
    localparam logic [1:0]     CTR_RESET    = 2'b01;

    // Widest counter the helper below supports
    localparam int                   CTR_MAX_W = 8;
    localparam logic [CTR_MAX_W-1:0] CTR_ONE   = 1;

    function automatic logic is_cond(input logic [2:0] t);
        return (t != BR_NONE) && (t != BR_JUMP);
    endfunction

    // Saturating step of a `bits`-wide counter held right-aligned
    function automatic logic [CTR_MAX_W-1:0] sat_next(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 taken,
        input int                   bits
    );
        logic [CTR_MAX_W:0]   lim;
        logic [CTR_MAX_W-1:0] top;
        lim = {{CTR_MAX_W{1'b0}}, 1'b1} << bits;
        top = lim[CTR_MAX_W-1:0] - CTR_ONE;
        if (taken) begin
            return (ctr >= top) ? top : ctr + CTR_ONE;
        end
        return (ctr == '0) ? '0 : ctr - CTR_ONE;
    endfunction

endpackage

// File: rtl/branch_predictor_stats.sv
// Performance counters: resolved conditional branches, mispredictions
// and a one-cycle mispredict pulse. Ports: clk, rst_n, fire_i, miss_i,
// mispredict_o, br_count_o, miss_count_o.
module bp_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fire_i,
    input  logic        miss_i,
    output logic        mispredict_o,
    output logic [31:0] br_count_o,
    output logic [31:0] miss_count_o
);

    logic        mp_q, mp_d;
    logic [31:0] br_q, br_d;
    logic [31:0] miss_q, miss_d;

    always_comb begin
        mp_d   = fire_i && miss_i;
        br_d   = br_q + (fire_i ? 32'd1 : 32'd0);
        miss_d = miss_q + (mp_d ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mp_q   <= 1'b0;
            br_q   <= '0;
            miss_q <= '0;
        end else begin
            mp_q   <= mp_d;
            br_q   <= br_d;
            miss_q <= miss_d;
        end
    end

    assign mispredict_o = mp_q;
    assign br_count_o   = br_q;
    assign miss_count_o = miss_q;

endmodule

// File: rtl/branch_predictor.sv
// PC-indexed table of saturating counters with a one-stage update pipe.
// Ports: pred_* lookup, upd_* training, mispredict/br_count/miss_count.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int CTR_BITS = CTR_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pred_pc,
    input  logic [2:0]  pred_br_type,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [2:0]  upd_br_type,
    input  logic        upd_taken,
    input  logic        upd_pred,
    output logic        mispredict,
    output logic [31:0] br_count,
    output logic [31:0] miss_count
);

    localparam int N = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] RST_VAL =
        {1'b0, {(CTR_BITS-1){1'b1}}};

    logic [CTR_BITS-1:0] table_q [N];

    logic                q_vld_q, q_vld_d;
    logic [IDX_BITS-1:0] q_idx_q, q_idx_d;
    logic                q_tkn_q, q_tkn_d;

    logic [IDX_BITS-1:0]  pred_idx, upd_idx;
    logic [CTR_MAX_W-1:0] q_ctr_w;
    logic [CTR_BITS-1:0]  q_new, eff;
    logic                 upd_fire;
    logic                 unused_pc;

    assign pred_idx = pred_pc[IDX_BITS+1:2];
    assign upd_idx  = upd_pc[IDX_BITS+1:2];
    assign upd_fire = upd_valid && is_cond(upd_br_type);

    assign unused_pc = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                         upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

    always_comb begin
        q_vld_d = upd_fire;
        q_idx_d = upd_idx;
        q_tkn_d = upd_taken;
    end

    // The previous stage write has already landed, so the table read
    // is current even for back-to-back updates to one index.
    assign q_ctr_w = sat_next(CTR_MAX_W'(table_q[q_idx_q]),
                              q_tkn_q, CTR_BITS);
    assign q_new   = CTR_BITS'(q_ctr_w);

    // Lookup sees the pending write before it reaches the table
    assign eff = (q_vld_q && (pred_idx == q_idx_q)) ? q_new
                                                    : table_q[pred_idx];

    always_comb begin
        pred_taken = 1'b0;
        if (is_cond(pred_br_type)) begin
            pred_taken = eff[CTR_BITS-1];
        end else if (pred_br_type == BR_JUMP) begin
            pred_taken = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_vld_q <= 1'b0;
            q_idx_q <= '0;
            q_tkn_q <= 1'b0;
        end else begin
            q_vld_q <= q_vld_d;
            q_idx_q <= q_idx_d;
            q_tkn_q <= q_tkn_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                table_q[i] <= RST_VAL;
            end
        end else if (q_vld_q) begin
            table_q[q_idx_q] <= q_new;
        end
    end

    bp_stats u_stats (
        .clk          (clk),
        .rst_n        (rst_n),
        .fire_i       (upd_fire),
        .miss_i       (upd_pred != upd_taken),
        .mispredict_o (mispredict),
        .br_count_o   (br_count),
        .miss_count_o (miss_count)
    );

endmodule
